// File: rtl/dino_pkg.sv
// Shared definitions for the dinosaur runner: game state encoding, RGB444
// colour constants, the BCD score ceiling and a packed-BCD increment helper.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [11:0] COL_BG        = 12'hFFF;
  localparam logic [11:0] COL_GROUND    = 12'h555;
  localparam logic [11:0] COL_CACTUS    = 12'h070;
  localparam logic [11:0] COL_DINO      = 12'h333;
  localparam logic [11:0] COL_DINO_DEAD = 12'hF00;

  localparam logic [15:0] BCD_MAX = 16'h9999;

  // Add one to a 4-digit packed BCD value; a digit at 9 wraps to 0 and
  // carries into the next digit. Callers handle saturation.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit packed BCD counter.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   clr   : synchronous clear (has priority over inc)
//   inc   : increment by one, holding at 9999
//   q     : count, digit 3 in [15:12]
module bcd_counter4
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != BCD_MAX)) begin
      q <= bcd_inc(q);
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Dinosaur runner game controller and pixel compositor.
// Detects dino/cactus overlap inside the visible area, runs the
// IDLE/RUN/OVER game flow, keeps BCD score and high score, and composes the
// final RGB444 pixel (dino > cactus > ground > background).
//   clkdiv      : clock bus, only clkdiv[0] is used
//   N_rst       : asynchronous active-low reset
//   row_addr    : current scan row
//   col_addr    : current scan column
//   fresh       : frame strobe, falling edge marks a frame tick
//   btn_start   : debounced start button (level)
//   ground_px   : ground pixel
//   dino_px     : dino pixel
//   cactus_px   : cactus pixel
//   game_status : high while running
//   game_over   : high while game over
//   score       : 4-digit BCD score
//   hi_score    : 4-digit BCD high score
//   px_color    : registered RGB444 output colour
module game_ctrl
  import dino_pkg::*;
#(
  parameter int HOLD_FRAMES = 30,
  parameter int ACTIVE_W    = 640,
  parameter int ACTIVE_H    = 480
) (
  input  logic [31:0] clkdiv,
  input  logic        N_rst,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        fresh,
  input  logic        btn_start,
  input  logic        ground_px,
  input  logic        dino_px,
  input  logic        cactus_px,
  output logic        game_status,
  output logic        game_over,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [11:0] px_color
);

  localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

  logic clk;
  assign clk = clkdiv[0];

  logic unused_clkdiv;
  assign unused_clkdiv = &{1'b0, clkdiv[31:1]};

  state_t            state;
  logic              fresh_q;
  logic              btn_q;
  logic              hit;
  logic [HOLD_W-1:0] hold_cnt;

  logic tick;
  logic start_rise;
  logic in_active;
  logic overlap;
  logic collide;
  logic hold_done;
  logic score_clr;
  logic score_inc;

  assign tick       = fresh_q & ~fresh;
  assign start_rise = ~btn_q & btn_start;
  assign in_active  = (32'(row_addr) < ACTIVE_H) && (32'(col_addr) < ACTIVE_W);
  assign overlap    = dino_px & cactus_px & in_active;
  // An overlap in the tick cycle itself still belongs to the ending frame.
  assign collide    = hit | overlap;
  assign hold_done  = (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      fresh_q <= 1'b0;
      btn_q   <= 1'b0;
      hit     <= 1'b0;
    end else begin
      fresh_q <= fresh;
      btn_q   <= btn_start;
      if (tick) begin
        hit <= 1'b0;
      end else if (overlap) begin
        hit <= 1'b1;
      end
    end
  end

  always_comb begin
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (state)
      ST_IDLE: score_clr = start_rise;
      ST_RUN:  score_inc = tick & ~collide;
      ST_OVER: score_clr = start_rise & hold_done;
      default: ;
    endcase
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rst_n (N_rst),
    .clr   (score_clr),
    .inc   (score_inc),
    .q     (score)
  );

  // Status outputs are written alongside the state so they decode the state
  // the FSM is entering, one cycle after the triggering event.
  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      state       <= ST_IDLE;
      game_status <= 1'b0;
      game_over   <= 1'b0;
      hold_cnt    <= '0;
      hi_score    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_rise) begin
            state       <= ST_RUN;
            game_status <= 1'b1;
          end
        end
        ST_RUN: begin
          if (tick && collide) begin
            state       <= ST_OVER;
            game_status <= 1'b0;
            game_over   <= 1'b1;
            hold_cnt    <= '0;
            if (score > hi_score) begin
              hi_score <= score;
            end
          end
        end
        ST_OVER: begin
          if (start_rise && hold_done) begin
            state       <= ST_RUN;
            game_status <= 1'b1;
            game_over   <= 1'b0;
            hold_cnt    <= '0;
          end else if (tick && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          game_status <= 1'b0;
          game_over   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge N_rst) begin
    if (!N_rst) begin
      px_color <= '0;
    end else if (!in_active) begin
      px_color <= '0;
    end else if (dino_px) begin
      px_color <= (state == ST_OVER) ? COL_DINO_DEAD : COL_DINO;
    end else if (cactus_px) begin
      px_color <= COL_CACTUS;
    end else if (ground_px) begin
      px_color <= COL_GROUND;
    end else begin
      px_color <= COL_BG;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
module tb_game_ctrl;

  localparam int HOLD = 30;

  logic        clk = 1'b0;
  logic        N_rst;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        fresh, btn_start, ground_px, dino_px, cactus_px;
  logic        game_status, game_over;
  logic [15:0] score, hi_score;
  logic [11:0] px_color;

  always #5 clk = ~clk;

  game_ctrl #(.HOLD_FRAMES(HOLD), .ACTIVE_W(640), .ACTIVE_H(480)) dut (
    .clkdiv      ({31'd0, clk}),
    .N_rst       (N_rst),
    .row_addr    (row_addr),
    .col_addr    (col_addr),
    .fresh       (fresh),
    .btn_start   (btn_start),
    .ground_px   (ground_px),
    .dino_px     (dino_px),
    .cactus_px   (cactus_px),
    .game_status (game_status),
    .game_over   (game_over),
    .score       (score),
    .hi_score    (hi_score),
    .px_color    (px_color)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: game as booleans plus decimal integers.
  bit          m_run, m_over, m_hit, m_fp, m_bp;
  int          m_score, m_hi, m_hold;
  logic [11:0] m_px;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    m_run = 0; m_over = 0; m_hit = 0; m_fp = 0; m_bp = 0;
    m_score = 0; m_hi = 0; m_hold = 0; m_px = 12'h000;
  endtask

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic clk_step();
    bit tk, rise, act, ov, coll;
    tk   = m_fp && !fresh;
    rise = !m_bp && btn_start;
    act  = (row_addr < 480) && (col_addr < 640);
    ov   = dino_px && cactus_px && act;
    coll = m_hit || ov;
    if (!act)           m_px = 12'h000;
    else if (dino_px)   m_px = m_over ? 12'hF00 : 12'h333;
    else if (cactus_px) m_px = 12'h070;
    else if (ground_px) m_px = 12'h555;
    else                m_px = 12'hFFF;
    if (!m_run && !m_over) begin
      if (rise) begin m_run = 1; m_score = 0; end
    end else if (m_run) begin
      if (tk) begin
        if (coll) begin
          m_run = 0; m_over = 1; m_hold = 0;
          if (m_score > m_hi) m_hi = m_score;
        end else if (m_score < 9999) begin
          m_score++;
        end
      end
    end else begin
      if (rise && m_hold == HOLD) begin
        m_over = 0; m_run = 1; m_score = 0; m_hold = 0;
      end else if (tk && m_hold < HOLD) begin
        m_hold++;
      end
    end
    if (tk) m_hit = 0; else if (ov) m_hit = 1;
    m_fp = fresh;
    m_bp = btn_start;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    row_addr = 9'd10; col_addr = 10'd10;
    ground_px = 1'b1; dino_px = 1'b0; cactus_px = 1'b0;
  endtask

  task automatic do_tick();
    fresh = 1'b1; clk_step();
    fresh = 1'b0; clk_step();
  endtask

  task automatic press();
    btn_start = 1'b1; clk_step();
    btn_start = 1'b0; clk_step();
  endtask

  task automatic test_reset();
    quiet(); fresh = 1'b0; btn_start = 1'b0;
    #2;
    N_rst = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (game_status !== 1'b0) begin n_bad++; $display("FAIL rst_status got %b want 0", game_status); end
    n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL rst_over got %b want 0", game_over); end
    n_cmp++; if (score !== 16'h0) begin n_bad++; $display("FAIL rst_score got %h want 0000", score); end
    n_cmp++; if (hi_score !== 16'h0) begin n_bad++; $display("FAIL rst_hi got %h want 0000", hi_score); end
    n_cmp++; if (px_color !== 12'h0) begin n_bad++; $display("FAIL rst_px got %h want 000", px_color); end
    @(posedge clk); #1;
    N_rst = 1'b1;
  endtask

  // Start rise coinciding with a tick in IDLE: start wins.
  task automatic test_start();
    quiet();
    fresh = 1'b1; clk_step();
    fresh = 1'b0; btn_start = 1'b1; clk_step();
    n_cmp++; if (game_status !== 1'b1) begin n_bad++; $display("FAIL start_status got %b want 1", game_status); end
    n_cmp++; if (score !== 16'h0) begin n_bad++; $display("FAIL start_score got %h want 0000", score); end
    btn_start = 1'b0; clk_step();
  endtask

  task automatic test_run();
    logic [8:0]  rows [5] = '{9'd200, 9'd200, 9'd200, 9'd200, 9'd479};
    logic [9:0]  cols [5] = '{10'd300, 10'd300, 10'd300, 10'd300, 10'd640};
    logic [2:0]  gdc  [5] = '{3'b100, 3'b000, 3'b010, 3'b111, 3'b111};
    logic [11:0] want [5] = '{12'h555, 12'hFFF, 12'h333, 12'h333, 12'h000};
    quiet();
    for (int i = 0; i < 12; i++) do_tick();
    n_cmp++; if (score !== 16'h0012) begin n_bad++; $display("FAIL run_score got %h want 0012", score); end
    for (int i = 0; i < 5; i++) begin
      row_addr = rows[i]; col_addr = cols[i];
      {ground_px, dino_px, cactus_px} = gdc[i];
      if (i == 3) cactus_px = 1'b0;
      clk_step();
      n_cmp++; if (px_color !== want[i]) begin n_bad++; $display("FAIL run_px%0d got %h want %h", i, px_color, want[i]); end
    end
    row_addr = 9'd100; col_addr = 10'd100; {ground_px, dino_px, cactus_px} = 3'b001;
    clk_step();
    n_cmp++; if (px_color !== 12'h070) begin n_bad++; $display("FAIL run_cactus got %h want 070", px_color); end
    quiet();
    press();
    n_cmp++; if (game_status !== 1'b1 || score !== 16'h0012) begin
      n_bad++; $display("FAIL run_btn_ignored got %b/%h want 1/0012", game_status, score);
    end
  endtask

  task automatic test_collision();
    row_addr = 9'd500; col_addr = 10'd100; dino_px = 1'b1; cactus_px = 1'b1;
    clk_step();
    quiet();
    do_tick();
    n_cmp++; if (game_status !== 1'b1 || score !== 16'h0013) begin
      n_bad++; $display("FAIL offscreen_overlap got %b/%h want 1/0013", game_status, score);
    end
    row_addr = 9'd300; col_addr = 10'd100; dino_px = 1'b1; cactus_px = 1'b1;
    clk_step();
    quiet();
    clk_step();
    do_tick();
    n_cmp++; if (game_over !== 1'b1 || game_status !== 1'b0) begin
      n_bad++; $display("FAIL hit_over got %b/%b want 1/0", game_over, game_status);
    end
    n_cmp++; if (score !== 16'h0013) begin n_bad++; $display("FAIL hit_score got %h want 0013", score); end
    n_cmp++; if (hi_score !== 16'h0013) begin n_bad++; $display("FAIL hit_hi got %h want 0013", hi_score); end
    row_addr = 9'd50; col_addr = 10'd50; dino_px = 1'b1;
    clk_step();
    n_cmp++; if (px_color !== 12'hF00) begin n_bad++; $display("FAIL dead_px got %h want F00", px_color); end
    quiet();
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) do_tick();
    press();
    n_cmp++; if (game_over !== 1'b1 || game_status !== 1'b0) begin
      n_bad++; $display("FAIL early_start got %b/%b want 1/0", game_over, game_status);
    end
    for (int i = 0; i < 19; i++) do_tick();
    press();
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL hold29 got %b want 1", game_over); end
    do_tick();
    press();
    n_cmp++; if (game_status !== 1'b1 || game_over !== 1'b0) begin
      n_bad++; $display("FAIL restart got %b/%b want 1/0", game_status, game_over);
    end
    n_cmp++; if (score !== 16'h0) begin n_bad++; $display("FAIL restart_score got %h want 0000", score); end
    n_cmp++; if (hi_score !== 16'h0013) begin n_bad++; $display("FAIL restart_hi got %h want 0013", hi_score); end
  endtask

  task automatic test_tick_overlap();
    for (int i = 0; i < 3; i++) do_tick();
    fresh = 1'b1; clk_step();
    fresh = 1'b0; row_addr = 9'd300; col_addr = 10'd100; dino_px = 1'b1; cactus_px = 1'b1;
    clk_step();
    quiet();
    n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL tick_overlap got %b want 1", game_over); end
    n_cmp++; if (score !== 16'h0003 || hi_score !== 16'h0013) begin
      n_bad++; $display("FAIL tick_overlap_scores got %h/%h want 0003/0013", score, hi_score);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      row_addr  = 9'($urandom_range(0, 511));
      col_addr  = 10'($urandom_range(0, 1023));
      ground_px = 1'($urandom);
      dino_px   = ($urandom % 4) == 0;
      cactus_px = ($urandom % 5) == 0;
      fresh     = 1'($urandom);
      btn_start = ($urandom % 3) == 0;
      clk_step();
      n_cmp++; if (game_status !== m_run) begin n_bad++; $display("FAIL rnd_status cyc %0d got %b want %b", i, game_status, m_run); end
      n_cmp++; if (game_over !== m_over) begin n_bad++; $display("FAIL rnd_over cyc %0d got %b want %b", i, game_over, m_over); end
      n_cmp++; if (score !== to_bcd(m_score)) begin n_bad++; $display("FAIL rnd_score cyc %0d got %h want %h", i, score, to_bcd(m_score)); end
      n_cmp++; if (hi_score !== to_bcd(m_hi)) begin n_bad++; $display("FAIL rnd_hi cyc %0d got %h want %h", i, hi_score, to_bcd(m_hi)); end
      n_cmp++; if (px_color !== m_px) begin n_bad++; $display("FAIL rnd_px cyc %0d got %h want %h", i, px_color, m_px); end
    end
    btn_start = 1'b0;
  endtask

  task automatic test_saturate();
    test_reset();
    quiet();
    press();
    for (int i = 0; i < 9999; i++) do_tick();
    n_cmp++; if (score !== 16'h9999) begin n_bad++; $display("FAIL sat_reach got %h want 9999", score); end
    for (int i = 0; i < 5; i++) do_tick();
    n_cmp++; if (score !== 16'h9999) begin n_bad++; $display("FAIL sat_hold got %h want 9999", score); end
    row_addr = 9'd1; col_addr = 10'd1; dino_px = 1'b1; cactus_px = 1'b1;
    clk_step();
    quiet();
    do_tick();
    n_cmp++; if (game_over !== 1'b1 || hi_score !== 16'h9999) begin
      n_bad++; $display("FAIL sat_hi got %b/%h want 1/9999", game_over, hi_score);
    end
    n_cmp++; if (score !== to_bcd(m_score)) begin n_bad++; $display("FAIL sat_model got %h want %h", score, to_bcd(m_score)); end
  endtask

  initial begin
    N_rst = 1'b0;
    fresh = 1'b0; btn_start = 1'b0;
    quiet();
    model_reset();
    test_reset();
    test_start();
    test_run();
    test_collision();
    test_hold();
    test_tick_overlap();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
